// File: rtl/simple_pkg.sv
// Shared types for the SIMPLE fetch path: machine word, fetch FSM states and queue entry.
package simple_pkg;

   localparam int unsigned WORD_W = 16;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   typedef struct packed {
      word_t pc;
      word_t data;
   } fetch_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// DEPTH-entry ring buffer of {pc, data} fetch entries with head/tail pointers carrying a wrap bit.
module ifq_fifo
   import simple_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clock,
   input  logic                       resetN,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WORD_W-1:0]          wrPC,
   input  logic [WORD_W-1:0]          wrData,
   output logic [WORD_W-1:0]          rdPC,
   output logic [WORD_W-1:0]          rdData,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   fetch_entry_t  store_q [DEPTH];
   fetch_entry_t  head_entry;
   logic [PW-1:0] head_q;
   logic [PW-1:0] tail_q;

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         head_q <= '0;
         tail_q <= '0;
      end else if (flush) begin
         head_q <= '0;
         tail_q <= '0;
      end else begin
         if (push) tail_q <= tail_q + PW'(1);
         if (pop)  head_q <= head_q + PW'(1);
      end
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         for (int i = 0; i < DEPTH; i++) store_q[i] <= '0;
      end else if (push && !flush) begin
         store_q[tail_q[AW-1:0]] <= '{pc: wrPC, data: wrData};
      end
   end

   assign head_entry = store_q[head_q[AW-1:0]];
   assign rdPC       = head_entry.pc;
   assign rdData     = head_entry.data;
   // Pointers differ only in the wrap bit when full, so the difference is the occupancy.
   assign empty      = (head_q == tail_q);
   assign count      = tail_q - head_q;

endmodule

// File: rtl/instruction_fetch_queue.sv
// Sequential prefetcher feeding the instruction register; redirect flushes buffered and in-flight words.
// Optional IFQ_BYPASS_EN forwards an ack straight to ir* when the queue is empty.
module instruction_fetch_queue
   import simple_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter word_t       RESET_PC = 16'h0000
) (
   input  logic                       clock,
   input  logic                       resetN,
   output logic                       memReq,
   output logic [WORD_W-1:0]          memAddr,
   input  logic                       memAck,
   input  logic [WORD_W-1:0]          memData,
   output logic                       irValid,
   output logic [WORD_W-1:0]          irData,
   output logic [WORD_W-1:0]          irPC,
   input  logic                       irTake,
   input  logic                       redirect,
   input  logic [WORD_W-1:0]          redirectPC,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned   CW         = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   fetch_state_t  state_q, state_d;
   word_t         fetch_pc_q, fetch_pc_d;
   word_t         mem_addr_q, mem_addr_d;
   word_t         head_pc, head_data;
   logic          ack_req;
   logic          fifo_empty;
   logic          fifo_push;
   logic          fifo_pop;
   logic          bypass_take;
   logic [CW-1:0] count_next;

   assign ack_req = (state_q == REQ) && memAck;

`ifdef IFQ_BYPASS_EN
   logic bypass;
   assign bypass      = ack_req && fifo_empty && !redirect;
   assign bypass_take = bypass && irTake;
   assign irValid     = !fifo_empty || bypass;
   assign irData      = bypass ? memData    : head_data;
   assign irPC        = bypass ? mem_addr_q : head_pc;
`else
   assign bypass_take = 1'b0;
   assign irValid     = !fifo_empty;
   assign irData      = head_data;
   assign irPC        = head_pc;
`endif

   // Redirect overrides both the pop and any ack write in the same cycle.
   assign fifo_pop   = irTake && !fifo_empty && !redirect;
   assign fifo_push  = ack_req && !redirect && !bypass_take;
   assign count_next = count + CW'(fifo_push) - CW'(fifo_pop);

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      mem_addr_d = mem_addr_q;
      case (state_q)
         IDLE: begin
            if (redirect) begin
               state_d    = REQ;
               mem_addr_d = redirectPC;
            end else if (count < FULL_COUNT) begin
               state_d    = REQ;
               mem_addr_d = fetch_pc_q;
            end
         end
         REQ: begin
            if (redirect) begin
               if (memAck) mem_addr_d = redirectPC;
               else        state_d    = DRAIN;
            end else if (memAck) begin
               fetch_pc_d = fetch_pc_q + 16'd1;
               mem_addr_d = fetch_pc_q + 16'd1;
               if (count_next >= FULL_COUNT) state_d = IDLE;
            end
         end
         DRAIN: begin
            // The in-flight word is stale; its address stays on the bus until it returns.
            if (memAck) begin
               state_d    = REQ;
               mem_addr_d = redirect ? redirectPC : fetch_pc_q;
            end
         end
         default: state_d = IDLE;
      endcase
      if (redirect) fetch_pc_d = redirectPC;
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         mem_addr_q <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         mem_addr_q <= mem_addr_d;
      end
   end

   assign memReq  = (state_q != IDLE);
   assign memAddr = mem_addr_q;

   ifq_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock  (clock),
      .resetN (resetN),
      .push   (fifo_push),
      .pop    (fifo_pop),
      .flush  (redirect),
      .wrPC   (mem_addr_q),
      .wrData (memData),
      .rdPC   (head_pc),
      .rdData (head_data),
      .empty  (fifo_empty),
      .count  (count)
   );

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue; a second instance covers the wrapping RESET_PC case.
`timescale 1ns/1ps
module tb_instruction_fetch_queue;

   logic        clock = 1'b0;
   logic        resetN;
   logic        memReq, memAck, irValid, irTake, redirect;
   logic [15:0] memAddr, memData, irData, irPC, redirectPC;
   logic [2:0]  count;

   logic        memReq2, memAck2, irValid2;
   logic        irTake2    = 1'b0;
   logic        redirect2  = 1'b0;
   logic [15:0] redirectPC2 = 16'h0000;
   logic [15:0] memAddr2, memData2, irData2, irPC2;
   logic [2:0]  count2;

   int          checks = 0;
   int          errors = 0;
   int          lat = 0;
   int          cnt;
   logic        ack_r;
   logic [15:0] addrs2[$];

   always #5 clock = ~clock;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return a ^ 16'hBEEF;
   endfunction

   // Memory model: zero-wait when lat==0, otherwise a one-cycle ack after lat cycles of request.
   assign memAck   = (lat == 0) ? memReq : ack_r;
   assign memData  = mem_word(memAddr);
   assign memAck2  = memReq2;
   assign memData2 = mem_word(memAddr2);

   always @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         ack_r <= 1'b0;
         cnt   <= 0;
      end else if (ack_r || !memReq) begin
         ack_r <= 1'b0;
         cnt   <= 0;
      end else if (cnt + 1 >= lat) begin
         ack_r <= 1'b1;
      end else begin
         cnt <= cnt + 1;
      end
   end

   always @(negedge clock) begin
      if (resetN && memReq2 && addrs2.size() < 16) addrs2.push_back(memAddr2);
   end

   instruction_fetch_queue #(
      .DEPTH    (4),
      .RESET_PC (16'h0000)
   ) dut (
      .clock      (clock),
      .resetN     (resetN),
      .memReq     (memReq),
      .memAddr    (memAddr),
      .memAck     (memAck),
      .memData    (memData),
      .irValid    (irValid),
      .irData     (irData),
      .irPC       (irPC),
      .irTake     (irTake),
      .redirect   (redirect),
      .redirectPC (redirectPC),
      .count      (count)
   );

   instruction_fetch_queue #(
      .DEPTH    (4),
      .RESET_PC (16'hFFFE)
   ) dut_wrap (
      .clock      (clock),
      .resetN     (resetN),
      .memReq     (memReq2),
      .memAddr    (memAddr2),
      .memAck     (memAck2),
      .memData    (memData2),
      .irValid    (irValid2),
      .irData     (irData2),
      .irPC       (irPC2),
      .irTake     (irTake2),
      .redirect   (redirect2),
      .redirectPC (redirectPC2),
      .count      (count2)
   );

   task automatic test_reset();
      logic [15:0] seen[$];
      lat = 0; irTake = 1'b0; redirect = 1'b0; redirectPC = 16'h0000; resetN = 1'b0;
      @(negedge clock); @(negedge clock);
      checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL reset_memReq: got %b expected 0", memReq); end
      checks++; if (memAddr !== 16'h0000) begin errors++; $display("FAIL reset_memAddr: got %h expected 0000", memAddr); end
      checks++; if (irValid !== 1'b0) begin errors++; $display("FAIL reset_irValid: got %b expected 0", irValid); end
      checks++; if (irData !== 16'h0000) begin errors++; $display("FAIL reset_irData: got %h expected 0000", irData); end
      checks++; if (irPC !== 16'h0000) begin errors++; $display("FAIL reset_irPC: got %h expected 0000", irPC); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
      resetN = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (memReq && memAck) seen.push_back(memAddr);
      end
      checks++; if (seen.size() != 4) begin errors++; $display("FAIL fetch_len: got %0d expected 4", seen.size()); end
      for (int i = 0; i < 4; i++) begin
         logic [15:0] got;
         got = (i < seen.size()) ? seen[i] : 16'hxxxx;
         checks++; if (got !== 16'(i)) begin errors++; $display("FAIL fetch_addr%0d: got %h expected %h", i, got, 16'(i)); end
      end
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", count); end
      checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL full_memReq: got %b expected 0", memReq); end
      checks++; if (irValid !== 1'b1) begin errors++; $display("FAIL full_irValid: got %b expected 1", irValid); end
      checks++; if (irData !== mem_word(16'h0000)) begin errors++; $display("FAIL full_irData: got %h expected %h", irData, mem_word(16'h0000)); end
      checks++; if (irPC !== 16'h0000) begin errors++; $display("FAIL full_irPC: got %h expected 0000", irPC); end
   endtask

   task automatic test_wrap();
      logic [15:0] exp_addr [4];
      exp_addr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
      checks++; if (addrs2.size() != 4) begin errors++; $display("FAIL wrap_len: got %0d expected 4", addrs2.size()); end
      for (int i = 0; i < 4; i++) begin
         logic [15:0] got;
         got = (i < addrs2.size()) ? addrs2[i] : 16'hxxxx;
         checks++; if (got !== exp_addr[i]) begin errors++; $display("FAIL wrap_addr%0d: got %h expected %h", i, got, exp_addr[i]); end
      end
      checks++; if (count2 !== 3'd4) begin errors++; $display("FAIL wrap_count: got %0d expected 4", count2); end
      checks++; if (irPC2 !== 16'hFFFE) begin errors++; $display("FAIL wrap_irPC: got %h expected fffe", irPC2); end
      checks++; if (irData2 !== mem_word(16'hFFFE)) begin errors++; $display("FAIL wrap_irData: got %h expected %h", irData2, mem_word(16'hFFFE)); end
   endtask

   task automatic test_take_refill();
      irTake = 1'b1;
      @(negedge clock);
      irTake = 1'b0;
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL take_count: got %0d expected 3", count); end
      checks++; if (irPC !== 16'h0001) begin errors++; $display("FAIL take_irPC: got %h expected 0001", irPC); end
      @(negedge clock);
      checks++; if (memReq !== 1'b1) begin errors++; $display("FAIL refill_memReq: got %b expected 1", memReq); end
      checks++; if (memAddr !== 16'h0004) begin errors++; $display("FAIL refill_memAddr: got %h expected 0004", memAddr); end
      @(negedge clock);
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL refill_count: got %0d expected 4", count); end
      checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL refill_idle: got %b expected 0", memReq); end
      checks++; if (irData !== mem_word(16'h0001)) begin errors++; $display("FAIL refill_irData: got %h expected %h", irData, mem_word(16'h0001)); end
   endtask

   task automatic test_redirect_drain();
      lat = 3;
      irTake = 1'b1;
      @(negedge clock);
      irTake = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (memReq) break;
         @(negedge clock);
      end
      checks++; if (memReq !== 1'b1) begin errors++; $display("FAIL async_setup: got memReq %b expected 1", memReq); end
      resetN = 1'b0;
      #1;
      checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL async_memReq: got %b expected 0", memReq); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL async_count: got %0d expected 0", count); end
      @(negedge clock); @(negedge clock);
      resetN = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (memReq && memAddr == 16'h0002) break;
         @(negedge clock);
      end
      checks++; if (memAddr !== 16'h0002) begin errors++; $display("FAIL drain_setup: got %h expected 0002", memAddr); end
      redirect = 1'b1; redirectPC = 16'h0040;
      @(negedge clock);
      redirect = 1'b0;
      checks++; if (memReq !== 1'b1) begin errors++; $display("FAIL drain_memReq: got %b expected 1", memReq); end
      checks++; if (memAddr !== 16'h0002) begin errors++; $display("FAIL drain_memAddr: got %h expected 0002", memAddr); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_count: got %0d expected 0", count); end
      checks++; if (irValid !== 1'b0) begin errors++; $display("FAIL drain_irValid: got %b expected 0", irValid); end
      for (int i = 0; i < 40; i++) begin
         if (memAck) break;
         @(negedge clock);
      end
      checks++; if (memAck !== 1'b1 || memAddr !== 16'h0002) begin errors++; $display("FAIL drain_ack: got ack %b addr %h expected ack 1 addr 0002", memAck, memAddr); end
      @(negedge clock);
      checks++; if (memReq !== 1'b1 || memAddr !== 16'h0040) begin errors++; $display("FAIL drain_refetch: got req %b addr %h expected req 1 addr 0040", memReq, memAddr); end
      checks++; if (irValid !== 1'b0) begin errors++; $display("FAIL drain_discard: got irValid %b expected 0", irValid); end
      for (int i = 0; i < 40; i++) begin
         if (irValid) break;
         @(negedge clock);
      end
      checks++; if (irPC !== 16'h0040) begin errors++; $display("FAIL drain_irPC: got %h expected 0040", irPC); end
      checks++; if (irData !== mem_word(16'h0040)) begin errors++; $display("FAIL drain_irData: got %h expected %h", irData, mem_word(16'h0040)); end
   endtask

   task automatic test_redirect_take();
      for (int i = 0; i < 40; i++) begin
         if (count == 3'd3) break;
         @(negedge clock);
      end
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL rt_setup: got count %0d expected 3", count); end
      redirect = 1'b1; redirectPC = 16'h0100; irTake = 1'b1;
      @(negedge clock);
      redirect = 1'b0; irTake = 1'b0;
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL rt_count: got %0d expected 0", count); end
      checks++; if (irValid !== 1'b0) begin errors++; $display("FAIL rt_irValid: got %b expected 0", irValid); end
      for (int i = 0; i < 40; i++) begin
         if (irValid) break;
         @(negedge clock);
      end
      checks++; if (irPC !== 16'h0100) begin errors++; $display("FAIL rt_irPC: got %h expected 0100", irPC); end
      checks++; if (irData !== mem_word(16'h0100)) begin errors++; $display("FAIL rt_irData: got %h expected %h", irData, mem_word(16'h0100)); end
   endtask

   task automatic test_bypass();
      redirect = 1'b1; redirectPC = 16'h0200;
      @(negedge clock);
      redirect = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (memReq && memAddr == 16'h0200) break;
         @(negedge clock);
      end
      checks++; if (memAddr !== 16'h0200) begin errors++; $display("FAIL byp_setup: got %h expected 0200", memAddr); end
      for (int i = 0; i < 40; i++) begin
         if (memAck) break;
         @(negedge clock);
      end
      checks++; if (memAck !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL byp_ack: got ack %b count %0d expected ack 1 count 0", memAck, count); end
`ifdef IFQ_BYPASS_EN
      checks++; if (irValid !== 1'b1) begin errors++; $display("FAIL byp_irValid: got %b expected 1", irValid); end
      checks++; if (irData !== mem_word(16'h0200)) begin errors++; $display("FAIL byp_irData: got %h expected %h", irData, mem_word(16'h0200)); end
      checks++; if (irPC !== 16'h0200) begin errors++; $display("FAIL byp_irPC: got %h expected 0200", irPC); end
      irTake = 1'b1;
      @(negedge clock);
      irTake = 1'b0;
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL byp_count: got %0d expected 0", count); end
`else
      checks++; if (irValid !== 1'b0) begin errors++; $display("FAIL nobyp_irValid0: got %b expected 0", irValid); end
      irTake = 1'b1;
      @(negedge clock);
      irTake = 1'b0;
      checks++; if (irValid !== 1'b1) begin errors++; $display("FAIL nobyp_irValid1: got %b expected 1", irValid); end
      checks++; if (irPC !== 16'h0200) begin errors++; $display("FAIL nobyp_irPC: got %h expected 0200", irPC); end
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL nobyp_count: got %0d expected 1", count); end
`endif
   endtask

   initial begin
      test_reset();
      test_wrap();
      test_take_refill();
      test_redirect_drain();
      test_redirect_take();
      test_bypass();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/instruction_fetch_queue.md
# instruction_fetch_queue

Prefetch stage directly upstream of the SIMPLE controller's instruction register. Issues sequential word reads to instruction memory over a req/ack handshake, buffers up to DEPTH fetched words with their addresses, and presents the head word to the controller, which consumes it in phase P1. A taken branch redirects fetch and flushes every buffered and in-flight word.

## Interface
- DEPTH, 4, queue entries; power of two, 2..16
- RESET_PC, 16'h0000, first fetch address after reset
- clock  in  1  rising-edge clock
- resetN  in  1  asynchronous, active-low reset
- memReq  out  1  read request; held high until memAck
- memAddr  out  16  word address; stable while memReq high and memAck low
- memAck  in  1  memData valid this cycle; request complete
- memData  in  16  fetched instruction word
- irValid  out  1  head entry available
- irData  out  16  head instruction word
- irPC  out  16  address of head instruction
- irTake  in  1  controller consumes head this cycle
- redirect  in  1  branch taken: flush and refetch
- redirectPC  in  16  new fetch address, sampled when redirect high
- count  out  $clog2(DEPTH+1)  entries currently buffered

## Operation
- Reset values: memReq 0, memAddr RESET_PC, irValid 0, irData 0, irPC 0, count 0, fetchPC RESET_PC, state IDLE.
- States: IDLE (no request), REQ (request outstanding, result kept), DRAIN (request outstanding, result discarded).
- IDLE→REQ when count < DEPTH (one slot always reserved for the outstanding word); memAddr <= fetchPC.
- REQ on memAck: write {memData, memAddr} at tail, fetchPC <= fetchPC+1; stay in REQ with memAddr = new fetchPC if a slot remains after the write and take, else go to IDLE.
- irTake with irValid: pop head. irTake with irValid low is ignored.
- redirect: count <= 0, fetchPC <= redirectPC. From IDLE: go to REQ at redirectPC. From REQ without memAck: go to DRAIN; memReq stays high and memAddr stays unchanged until memAck. From REQ with memAck in the same cycle: discard the data and issue redirectPC next cycle.
- DRAIN on memAck: discard the data and go to REQ at fetchPC. A redirect during DRAIN only updates fetchPC.
- Simultaneous events: redirect beats irTake, and beats any ack write in the same cycle. irTake and an ack write in the same cycle leave count unchanged.
- fetchPC wraps from 16'hFFFF to 16'h0000 without a flag.
- Assertion of resetN mid-request drops the request immediately: memReq goes to 0 asynchronously.

## Timing
- memReq rises on the first clock edge after resetN deasserts.
- ack→irValid: 1 cycle (storage is registered; irData and irPC are read combinationally from the head register).
- Throughput with a zero-wait memory (memAck in the same cycle as memReq): one word per cycle while slots remain.
- irTake→next head visible: the following cycle.
- redirect→memReq at redirectPC: the next cycle from IDLE or from REQ with a coincident ack; otherwise after the drained ack plus 1 cycle.
- count is registered and updates on the edge where the push or pop occurs.

## Configuration
- IFQ_BYPASS_EN defined: when the queue is empty and memAck arrives in REQ, irValid, irData and irPC reflect memData and memAddr combinationally in that same cycle. If irTake is also high in that cycle, the word is consumed and not written.
- IFQ_BYPASS_EN undefined: no combinational path from mem* to ir*, with the 1-cycle ack→irValid latency stated above.

## Structure
- Shared package simple_pkg holds:
  - WORD_W = 16 and word_t
  - the fetch state enum (IDLE, REQ, DRAIN)
  - the fetch entry struct {word_t pc; word_t data}
- Sub-module ifq_fifo provides DEPTH-entry ring storage:
  - head and tail pointers with an extra wrap bit
  - push, pop and flush inputs
  - count output
- instruction_fetch_queue contains the fetch FSM, fetchPC and the redirect logic.

## Test plan
- Reset release, zero-wait memory, no irTake: addresses 0,1,2,3 fetched, then memReq low; count=4 and irData = mem[0].
- Full queue, pulse irTake once: memReq reasserts with memAddr=4 and count returns to 4. Head shows mem[1], irPC=1.
- 3-cycle-latency memory, redirect to 16'h0040 while a request to 2 is pending: memReq held at addr 2 until ack, word discarded, then a request to 16'h0040 follows. First irPC=16'h0040.
- redirect and irTake in the same cycle with count=3: count=0 next cycle, irValid=0, and the next delivered irPC equals redirectPC.
- RESET_PC=16'hFFFE, DEPTH=4: fetched addresses FFFE, FFFF, 0000, 0001.
- With IFQ_BYPASS_EN, empty queue: memAck plus irTake in the same cycle gives irValid=1 with irData=memData that cycle, and count stays 0. Without the macro, irValid rises one cycle after memAck.
